// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, requester ids,
// FSM states and the LSU alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Size 2'b11 is reserved and always rejected.
  function automatic logic lsu_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is IFU, bit 1 is LSU.
// The pointer records who was served last and moves only when a grant is taken.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == ID_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset as if LSU was served last so IFU wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= ID_LSU;
    else if (advance && (|gnt))
      last_q <= gnt[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single data-memory port between instruction fetch and the LSU:
// round-robin grant, alignment check, RD_LAT-cycle reads, single-cycle writes.
//
//   state | meaning
//   IDLE  | ready to the grantee, accept and classify a request
//   RD    | mem_ren held RD_LAT cycles, rdata captured on the last one
//   WR    | mem_wen for one cycle
//   RESP  | one-cycle response pulse to the grantee
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [1:0]        lsu_size,
  input  logic              lsu_sext,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_suffix_b,
  output logic              mem_suffix_h,
  output logic              mem_sext,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                in_idle;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                accept;
  logic                acc_id;
  logic                acc_err;
  logic                acc_wen;

  assign in_idle = (state_q == IDLE);
  assign req     = in_idle ? {lsu_req_valid, ifu_req_valid} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign ifu_req_ready = gnt[0];
  assign lsu_req_ready = gnt[1];
  assign accept        = |gnt;
  assign acc_id        = gnt[1] ? ID_LSU : ID_IFU;
  assign acc_err       = (acc_id == ID_LSU) ? lsu_misaligned(lsu_addr[1:0], lsu_size)
                                            : (|ifu_addr[1:0]);
  assign acc_wen       = (acc_id == ID_LSU) && lsu_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    mem_ren        = 1'b0;
    mem_wen        = 1'b0;
    mem_raddr      = '0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    mem_suffix_b   = 1'b0;
    mem_suffix_h   = 1'b0;
    mem_sext       = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_err        = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = acc_err ? RESP : (acc_wen ? WR : RD);
      end
      RD: begin
        mem_ren      = 1'b1;
        mem_raddr    = addr_q;
        mem_suffix_b = (size_q == SZ_B);
        mem_suffix_h = (size_q == SZ_H);
        mem_sext     = sext_q;
        if (cnt_q == '0)
          state_d = RESP;
      end
      WR: begin
        mem_wen      = 1'b1;
        mem_waddr    = addr_q;
        mem_wdata    = wdata_q;
        mem_suffix_b = (size_q == SZ_B);
        mem_suffix_h = (size_q == SZ_H);
        state_d      = RESP;
      end
      RESP: begin
        if (id_q == ID_LSU) begin
          lsu_resp_valid = 1'b1;
          lsu_rdata      = rdata_q;
          lsu_err        = err_q;
        end else begin
          ifu_resp_valid = 1'b1;
          ifu_rdata      = rdata_q;
          ifu_err        = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdata_q is cleared on accept so stores and rejected requests respond with 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      id_q    <= ID_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (in_idle && accept) begin
      id_q    <= acc_id;
      addr_q  <= (acc_id == ID_LSU) ? lsu_addr : ifu_addr;
      wdata_q <= (acc_id == ID_LSU) ? lsu_wdata : '0;
      size_q  <= (acc_id == ID_LSU) ? lsu_size : SZ_W;
      sext_q  <= (acc_id == ID_LSU) && lsu_sext;
      err_q   <= acc_err;
      rdata_q <= '0;
      cnt_q   <= CNT_W'(RD_LAT - 1);
    end else if (state_q == RD) begin
      if (cnt_q == '0)
        rdata_q <= mem_rdata;
      else
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses,
// monitors pop and compare whenever a response pulse appears.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RD_LAT = 1 instance
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_sext, lsu_resp_valid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [1:0]  lsu_size;
  logic        mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;

  // RD_LAT = 3 instance
  logic        ifu3_req_valid, ifu3_req_ready, ifu3_resp_valid, ifu3_err;
  logic [31:0] ifu3_addr, ifu3_rdata;
  logic        lsu3_req_valid, lsu3_req_ready, lsu3_wen, lsu3_sext, lsu3_resp_valid, lsu3_err;
  logic [31:0] lsu3_addr, lsu3_wdata, lsu3_rdata;
  logic [1:0]  lsu3_size;
  logic        mem3_ren, mem3_wen, mem3_suffix_b, mem3_suffix_h, mem3_sext;
  logic [31:0] mem3_raddr, mem3_waddr, mem3_wdata, mem3_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_size(lsu_size), .lsu_sext(lsu_sext),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_suffix_b(mem_suffix_b), .mem_suffix_h(mem_suffix_h),
    .mem_sext(mem_sext), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu3_req_valid), .ifu_req_ready(ifu3_req_ready), .ifu_addr(ifu3_addr),
    .ifu_resp_valid(ifu3_resp_valid), .ifu_rdata(ifu3_rdata), .ifu_err(ifu3_err),
    .lsu_req_valid(lsu3_req_valid), .lsu_req_ready(lsu3_req_ready), .lsu_wen(lsu3_wen),
    .lsu_addr(lsu3_addr), .lsu_wdata(lsu3_wdata), .lsu_size(lsu3_size), .lsu_sext(lsu3_sext),
    .lsu_resp_valid(lsu3_resp_valid), .lsu_rdata(lsu3_rdata), .lsu_err(lsu3_err),
    .mem_ren(mem3_ren), .mem_wen(mem3_wen), .mem_raddr(mem3_raddr), .mem_waddr(mem3_waddr),
    .mem_wdata(mem3_wdata), .mem_suffix_b(mem3_suffix_b), .mem_suffix_h(mem3_suffix_h),
    .mem_sext(mem3_sext), .mem_rdata(mem3_rdata)
  );

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb3_q[$];
  exp_t mon_e, mon3_e;

  int          ren_cnt, wen_cnt, ren3_cnt, ren3_ok;
  logic [34:0] last_ren;   // {raddr, suffix_b, suffix_h, sext}
  logic [65:0] last_wen;   // {waddr, wdata, suffix_b, suffix_h}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic cmp_resp(input exp_t e, input bit is_lsu, input logic [31:0] rd,
                          input bit err, input logic [31:0] other_rd);
    chk("resp_id", is_lsu, e.lsu);
    chk("resp_rdata", rd, e.rdata);
    chk("resp_err", err, e.err);
    chk("resp_cycle", cyc, e.cyc);
    chk("resp_other_rdata", other_rd, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        chk("resp_onehot", ifu_resp_valid & lsu_resp_valid, 0);
        if (sb_q.size() == 0)
          chk("resp_unexpected", {ifu_resp_valid, lsu_resp_valid}, 0);
        else begin
          mon_e = sb_q.pop_front();
          cmp_resp(mon_e, lsu_resp_valid, lsu_resp_valid ? lsu_rdata : ifu_rdata,
                   lsu_resp_valid ? lsu_err : ifu_err, lsu_resp_valid ? ifu_rdata : lsu_rdata);
        end
      end
      if (ifu_req_ready || lsu_req_ready)
        chk("ready_excl", ifu_req_ready & lsu_req_ready, 0);
      if (mem_ren || mem_wen)
        chk("ren_wen_excl", mem_ren & mem_wen, 0);
      if (mem_ren) begin
        ren_cnt++;
        last_ren = {mem_raddr, mem_suffix_b, mem_suffix_h, mem_sext};
      end
      if (mem_wen) begin
        wen_cnt++;
        last_wen = {mem_waddr, mem_wdata, mem_suffix_b, mem_suffix_h};
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifu3_resp_valid || lsu3_resp_valid) begin
        if (sb3_q.size() == 0)
          chk("resp3_unexpected", {ifu3_resp_valid, lsu3_resp_valid}, 0);
        else begin
          mon3_e = sb3_q.pop_front();
          cmp_resp(mon3_e, lsu3_resp_valid, lsu3_resp_valid ? lsu3_rdata : ifu3_rdata,
                   lsu3_resp_valid ? lsu3_err : ifu3_err, lsu3_resp_valid ? ifu3_rdata : lsu3_rdata);
        end
      end
      if (mem3_ren) begin
        ren3_cnt++;
        if (mem3_raddr == 32'h8000_0010 && mem3_suffix_h && !mem3_suffix_b && mem3_sext)
          ren3_ok++;
      end
    end
  end

  task automatic wait_ready(input bit dut3, input bit lsu, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut3 ? lsu3_req_ready : (lsu ? lsu_req_ready : ifu_req_ready)) begin
        ok = 1'b1;
        n  = cyc;
        break;
      end
    end
    if (!ok) timeout("ready_wait");
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && sb3_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeout("resp_drain");
  endtask

  task automatic issue_ifu(input logic [31:0] addr, input logic [31:0] rd, input bit err, input int lat);
    int n;
    bit ok;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = addr;
    wait_ready(1'b0, 1'b0, n, ok);
    if (ok) sb_q.push_back('{lsu: 1'b0, rdata: rd, err: err, cyc: n + lat});
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
  endtask

  task automatic issue_lsu(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input bit sext,
                           input logic [31:0] rd, input bit err, input int lat);
    int n;
    bit ok;
    @(posedge clk); #1;
    lsu_req_valid = 1'b1;
    lsu_wen       = wen;
    lsu_addr      = addr;
    lsu_wdata     = wdata;
    lsu_size      = size;
    lsu_sext      = sext;
    wait_ready(1'b0, 1'b1, n, ok);
    if (ok) sb_q.push_back('{lsu: 1'b1, rdata: rd, err: err, cyc: n + lat});
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
  endtask

  // Both requesters held valid; grants must alternate IFU, LSU, IFU, ...
  task automatic rr_run(input int n);
    int k = 0;
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_0004;
    lsu_size      = SZ_W;
    lsu_sext      = 1'b0;
    for (int i = 0; i < 60 && k < n; i++) begin
      @(negedge clk);
      if (ifu_req_ready || lsu_req_ready) begin
        chk("rr_grant_is_lsu", lsu_req_ready, k % 2);
        sb_q.push_back('{lsu: bit'(k % 2), rdata: mem_rdata, err: 1'b0, cyc: cyc + 2});
        k++;
      end
    end
    if (k < n) timeout("rr_grants");
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_size = 0; lsu_sext = 0;
    mem_rdata = 0;
    ifu3_req_valid = 0; ifu3_addr = 0;
    lsu3_req_valid = 0; lsu3_wen = 0; lsu3_addr = 0; lsu3_wdata = 0; lsu3_size = 0; lsu3_sext = 0;
    mem3_rdata = 0;
    ren_cnt = 0; wen_cnt = 0; ren3_cnt = 0; ren3_ok = 0;
    last_ren = '0; last_wen = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext, ifu_resp_valid,
                     lsu_resp_valid, ifu_err, lsu_err, ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_addr", {mem_raddr, mem_waddr}, 0);
    chk("rst_data", {ifu_rdata, lsu_rdata}, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // Aligned fetch
    mem_rdata = 32'h0000_0413;
    ren_cnt = 0; wen_cnt = 0;
    issue_ifu(32'h8000_0000, 32'h0000_0413, 1'b0, 2);
    drain();
    chk("fetch_ren_cycles", ren_cnt, 1);
    chk("fetch_ren_ctrl", last_ren, {32'h8000_0000, 3'b000});

    // Byte store
    ren_cnt = 0; wen_cnt = 0;
    issue_lsu(1'b1, 32'h8000_0003, 32'h0000_00AB, SZ_B, 1'b0, 32'h0, 1'b0, 2);
    drain();
    chk("store_wen_cycles", wen_cnt, 1);
    chk("store_ren_cycles", ren_cnt, 0);
    chk("store_wen_ctrl", last_wen, {32'h8000_0003, 32'h0000_00AB, 2'b10});

    // Rejected requests: error at N+1 with no memory traffic
    ren_cnt = 0; wen_cnt = 0;
    issue_lsu(1'b0, 32'h8000_0002, 32'h0, SZ_W, 1'b0, 32'h0, 1'b1, 1);
    issue_lsu(1'b0, 32'h8000_0000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
    issue_lsu(1'b1, 32'h8000_0001, 32'h5555, SZ_H, 1'b0, 32'h0, 1'b1, 1);
    issue_ifu(32'h8000_0002, 32'h0, 1'b1, 1);
    drain();
    chk("err_no_mem_access", ren_cnt + wen_cnt, 0);

    // Round robin from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    mem_rdata = 32'h1234_5678;
    rr_run(4);
    drain();

    // Reset during RD: IFU was served last, yet IFU must win after reset
    @(posedge clk); #1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0020;
    wait_ready(1'b0, 1'b0, n, ok);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    chk("rd_ren_before_rst", mem_ren, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_ren_async", {mem_ren, mem_raddr}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    end
    rst_n = 1'b1;
    rr_run(2);
    drain();

    // RD_LAT = 3 half load with sign extension
    mem3_rdata = 32'hFFFF_8001;
    ren3_cnt = 0; ren3_ok = 0;
    @(posedge clk); #1;
    lsu3_req_valid = 1'b1;
    lsu3_wen       = 1'b0;
    lsu3_addr      = 32'h8000_0010;
    lsu3_size      = SZ_H;
    lsu3_sext      = 1'b1;
    wait_ready(1'b1, 1'b1, n, ok);
    if (ok) sb3_q.push_back('{lsu: 1'b1, rdata: 32'hFFFF_8001, err: 1'b0, cyc: n + 4});
    @(posedge clk); #1;
    lsu3_req_valid = 1'b0;
    drain();
    chk("lat3_ren_cycles", ren3_cnt, 3);
    chk("lat3_ren_ctrl_ok", ren3_ok, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
